// File: rtl/store_drain_buffer.sv
// store_drain_buffer: in-order posted-write queue between the Memory stage and the data-memory write port,
// with word-granular load alias detection and a fence/ecall flush handshake.
module store_drain_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enqValid,
    input  logic [DATA_WIDTH-1:0] enqAddr,
    input  logic [DATA_WIDTH-1:0] enqData,
    input  logic [2:0]            enqFunc3,
    output logic                  enqReady,
    output logic                  memReq,
    output logic [DATA_WIDTH-1:0] memAddr,
    output logic [DATA_WIDTH-1:0] memData,
    output logic [2:0]            memFunc3,
    input  logic                  memAck,
    input  logic                  ldCheckValid,
    input  logic [DATA_WIDTH-1:0] ldCheckAddr,
    output logic                  ldConflict,
    input  logic                  flush,
    output logic                  flushDone,
    output logic                  empty,
    output logic [CNT_WIDTH-1:0]  count
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic {IDLE, DRAIN} state_t;
    state_t state, state_next;
    logic [AW-1:0] head, tail;
    logic [DATA_WIDTH-1:0] addr_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [2:0] func_q [DEPTH];
    logic flush_pending, flush_done, push, pop, done_cond;
    assign enqReady = count < CNT_WIDTH'(DEPTH) && !flush_pending;
    assign push = enqValid && enqReady;
    assign pop = state == DRAIN && memAck;
    assign memReq = state == DRAIN;
    assign memAddr = addr_q[head];
    assign memData = data_q[head];
    assign memFunc3 = func_q[head];
    assign empty = count == '0;
    assign flushDone = flush_done;
    // a flush seen while already idle and empty completes without waiting a cycle in pending
    assign done_cond = (flush_pending || flush) && empty && state == IDLE && !push;
    always_comb begin
        state_next = state == IDLE ? (empty ? IDLE : DRAIN)
                                   : (pop && count == CNT_WIDTH'(1) && !push ? IDLE : DRAIN);
    end
    always_comb begin
        ldConflict = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ({1'b0, AW'(AW'(i) - head)} < count
                && addr_q[i][DATA_WIDTH-1:2] == ldCheckAddr[DATA_WIDTH-1:2])
                ldConflict = ldCheckValid;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            head <= '0;
            tail <= '0;
            count <= '0;
            flush_pending <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            state <= state_next;
            if (push) tail <= tail + AW'(1);
            if (pop) head <= head + AW'(1);
            count <= count + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
            flush_done <= done_cond;
            flush_pending <= !done_cond && (flush_pending || flush);
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail] <= enqAddr;
            data_q[tail] <= enqData;
            func_q[tail] <= enqFunc3;
        end
    end
endmodule

// File: tb/tb_store_drain_buffer.sv
// tb_store_drain_buffer: table-driven directed vectors for store_drain_buffer, plus a hand-written
// reset-while-draining sequence.
module tb_store_drain_buffer;
    logic clk = 1'b0, rst_n = 1'b0;
    logic enqValid = 1'b0, memAck = 1'b0, ldCheckValid = 1'b0, flush = 1'b0;
    logic [31:0] enqAddr = '0, enqData = '0, ldCheckAddr = '0;
    logic [2:0] enqFunc3 = '0;
    logic enqReady, memReq, ldConflict, flushDone, empty;
    logic [31:0] memAddr, memData;
    logic [2:0] memFunc3, count;

    always #5 clk = ~clk;

    store_drain_buffer #(.DATA_WIDTH(32), .DEPTH(4), .CNT_WIDTH(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .enqValid(enqValid), .enqAddr(enqAddr), .enqData(enqData), .enqFunc3(enqFunc3), .enqReady(enqReady),
        .memReq(memReq), .memAddr(memAddr), .memData(memData), .memFunc3(memFunc3), .memAck(memAck),
        .ldCheckValid(ldCheckValid), .ldCheckAddr(ldCheckAddr), .ldConflict(ldConflict),
        .flush(flush), .flushDone(flushDone), .empty(empty), .count(count)
    );

    typedef struct {
        logic ev; logic [31:0] ea, ed; logic [2:0] ef; logic ack, lv; logic [31:0] la; logic fl;
        logic rdy, req; logic [31:0] ma, md; logic [2:0] mf; logic conf, fd, emp; logic [2:0] cnt;
    } vec_t;

    vec_t tv[$];
    int n_vec = 0, n_err = 0;

    function automatic vec_t mk(input int ev, ea, ed, ef, ack, lv, la, fl,
                                input int rdy, req, ma, md, mf, conf, fd, emp, cnt);
        vec_t v;
        v.ev = 1'(ev); v.ea = ea; v.ed = ed; v.ef = 3'(ef); v.ack = 1'(ack);
        v.lv = 1'(lv); v.la = la; v.fl = 1'(fl);
        v.rdy = 1'(rdy); v.req = 1'(req); v.ma = ma; v.md = md; v.mf = 3'(mf);
        v.conf = 1'(conf); v.fd = 1'(fd); v.emp = 1'(emp); v.cnt = 3'(cnt);
        return v;
    endfunction

    // payload is only compared while a request is expected
    task automatic apply(input string name, input vec_t v);
        enqValid = v.ev; enqAddr = v.ea; enqData = v.ed; enqFunc3 = v.ef;
        memAck = v.ack; ldCheckValid = v.lv; ldCheckAddr = v.la; flush = v.fl;
        #1;
        n_vec++;
        if (enqReady !== v.rdy || memReq !== v.req || ldConflict !== v.conf || flushDone !== v.fd
            || empty !== v.emp || count !== v.cnt
            || (v.req && (memAddr !== v.ma || memData !== v.md || memFunc3 !== v.mf))) begin
            n_err++;
            $display("FAIL %s: got rdy=%0b req=%0b addr=%h data=%h f3=%0d conf=%0b fd=%0b empty=%0b count=%0d; want rdy=%0b req=%0b addr=%h data=%h f3=%0d conf=%0b fd=%0b empty=%0b count=%0d",
                     name, enqReady, memReq, memAddr, memData, memFunc3, ldConflict, flushDone, empty, count,
                     v.rdy, v.req, v.ma, v.md, v.mf, v.conf, v.fd, v.emp, v.cnt);
        end
        @(negedge clk);
    endtask

    initial begin
        // single sw, memAck tied high
        tv.push_back(mk(1, 'h1004, 'hDEADBEEF, 2, 1, 0, 0, 0,  1, 0, 0, 0, 0,  0, 0, 1, 0));
        tv.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0,  0, 0, 0, 1));
        tv.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0,  1, 1, 'h1004, 'hDEADBEEF, 2,  0, 0, 0, 1));
        tv.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0,  0, 0, 1, 0));
        // fill to 4 with memAck low, 5th dropped, then back-to-back retire
        tv.push_back(mk(1, 'h100, 1, 2, 0, 0, 0, 0,  1, 0, 0, 0, 0,  0, 0, 1, 0));
        tv.push_back(mk(1, 'h104, 2, 2, 0, 0, 0, 0,  1, 0, 0, 0, 0,  0, 0, 0, 1));
        tv.push_back(mk(1, 'h108, 3, 2, 0, 0, 0, 0,  1, 1, 'h100, 1, 2,  0, 0, 0, 2));
        tv.push_back(mk(1, 'h10C, 4, 2, 0, 0, 0, 0,  1, 1, 'h100, 1, 2,  0, 0, 0, 3));
        tv.push_back(mk(1, 'h110, 5, 2, 0, 0, 0, 0,  0, 1, 'h100, 1, 2,  0, 0, 0, 4));
        tv.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0,  0, 1, 'h100, 1, 2,  0, 0, 0, 4));
        tv.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0,  1, 1, 'h104, 2, 2,  0, 0, 0, 3));
        tv.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0,  1, 1, 'h108, 3, 2,  0, 0, 0, 2));
        tv.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0,  1, 1, 'h10C, 4, 2,  0, 0, 0, 1));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0,  0, 0, 1, 0));
        // wrapped pointers, simultaneous enqueue + ack at count 2
        tv.push_back(mk(1, 'h200, 'h11, 2, 1, 0, 0, 0,  1, 0, 0, 0, 0,  0, 0, 1, 0));
        tv.push_back(mk(1, 'h204, 'h12, 2, 1, 0, 0, 0,  1, 0, 0, 0, 0,  0, 0, 0, 1));
        tv.push_back(mk(1, 'h208, 'h13, 2, 1, 0, 0, 0,  1, 1, 'h200, 'h11, 2,  0, 0, 0, 2));
        tv.push_back(mk(1, 'h20C, 'h14, 2, 1, 0, 0, 0,  1, 1, 'h204, 'h12, 2,  0, 0, 0, 2));
        tv.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0,  1, 1, 'h208, 'h13, 2,  0, 0, 0, 2));
        tv.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0,  1, 1, 'h20C, 'h14, 2,  0, 0, 0, 1));
        tv.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0,  0, 0, 1, 0));
        // load aliasing at word granularity
        tv.push_back(mk(1, 'h2003, 'hAB, 0, 0, 1, 'h2000, 0,  1, 0, 0, 0, 0,  0, 0, 1, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 1, 'h2000, 0,  1, 0, 0, 0, 0,  1, 0, 0, 1));
        tv.push_back(mk(0, 0, 0, 0, 0, 1, 'h2004, 0,  1, 1, 'h2003, 'hAB, 0,  0, 0, 0, 1));
        tv.push_back(mk(0, 0, 0, 0, 1, 1, 'h2000, 0,  1, 1, 'h2003, 'hAB, 0,  1, 0, 0, 1));
        tv.push_back(mk(0, 0, 0, 0, 0, 1, 'h2000, 0,  1, 0, 0, 0, 0,  0, 0, 1, 0));
        // flush with three queued stores, blocked enqueue, single flushDone pulse
        tv.push_back(mk(1, 'h300, 'h31, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0,  0, 0, 1, 0));
        tv.push_back(mk(1, 'h304, 'h32, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0,  0, 0, 0, 1));
        tv.push_back(mk(1, 'h308, 'h33, 1, 0, 0, 0, 0,  1, 1, 'h300, 'h31, 1,  0, 0, 0, 2));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,  1, 1, 'h300, 'h31, 1,  0, 0, 0, 3));
        tv.push_back(mk(1, 'h30C, 'h34, 1, 0, 0, 0, 0,  0, 1, 'h300, 'h31, 1,  0, 0, 0, 3));
        tv.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0,  0, 1, 'h300, 'h31, 1,  0, 0, 0, 3));
        tv.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0,  0, 1, 'h304, 'h32, 1,  0, 0, 0, 2));
        tv.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0,  0, 1, 'h308, 'h33, 1,  0, 0, 0, 1));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 1, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0,  0, 1, 1, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0,  0, 0, 1, 0));
        // flush while already empty
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0,  0, 0, 1, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0,  0, 1, 1, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0,  0, 0, 1, 0));

        repeat (2) @(posedge clk);
        @(negedge clk);
        apply("reset", mk(0, 0, 0, 0, 0, 1, 0, 0,  1, 0, 0, 0, 0,  0, 0, 1, 0));
        rst_n = 1'b1;
        for (int i = 0; i < tv.size(); i++) apply($sformatf("vec%0d", i), tv[i]);

        // reset while draining three stores with a flush pending
        apply("rst_fill0", mk(1, 'h400, 'h41, 2, 0, 0, 0, 0,  1, 0, 0, 0, 0,  0, 0, 1, 0));
        apply("rst_fill1", mk(1, 'h404, 'h42, 2, 0, 0, 0, 0,  1, 0, 0, 0, 0,  0, 0, 0, 1));
        apply("rst_fill2", mk(1, 'h408, 'h43, 2, 0, 0, 0, 0,  1, 1, 'h400, 'h41, 2,  0, 0, 0, 2));
        apply("rst_flush", mk(0, 0, 0, 0, 0, 0, 0, 1,  1, 1, 'h400, 'h41, 2,  0, 0, 0, 3));
        rst_n = 1'b0;
        apply("rst_edge", mk(0, 0, 0, 0, 0, 1, 'h404, 0,  0, 1, 'h400, 'h41, 2,  1, 0, 0, 3));
        rst_n = 1'b1;
        apply("rst_after", mk(0, 0, 0, 0, 1, 1, 'h404, 0,  1, 0, 0, 0, 0,  0, 0, 1, 0));
        apply("rst_idle", mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0,  0, 0, 1, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/store_drain_buffer.md
Name: store_drain_buffer

Overview:
- Posted-write buffer between the Memory stage and the data memory's write port.
- Accepts stores (sb/sh/sw) from the pipeline in one cycle, queues them in order, and retires them to data memory over a req/ack handshake. This keeps multi-cycle memory writes from stalling the pipeline.
- Flags loads that alias a queued store so the hazard unit can stall them.
- Provides a flush handshake for fence/ecall.

Parameters:
- DATA_WIDTH, 32, address and data width
- DEPTH, 4, number of buffer entries; power of two, at least 2
- CNT_WIDTH, 3, width of count; equals log2(DEPTH)+1

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous reset, active-low
- enqValid  input  1  store presented by the Memory stage
- enqAddr  input  DATA_WIDTH  store byte address
- enqData  input  DATA_WIDTH  store data, unaligned as issued
- enqFunc3  input  3  store size (000 sb, 001 sh, 010 sw)
- enqReady  output  1  buffer can accept a store this cycle
- memReq  output  1  write request to data memory
- memAddr  output  DATA_WIDTH  head entry address
- memData  output  DATA_WIDTH  head entry data
- memFunc3  output  3  head entry size
- memAck  input  1  data memory has committed the head write
- ldCheckValid  input  1  a load is in the Memory stage
- ldCheckAddr  input  DATA_WIDTH  load byte address
- ldConflict  output  1  the load aliases a queued store
- flush  input  1  one-cycle pulse requesting a full drain
- flushDone  output  1  one-cycle pulse when the drain completes
- empty  output  1  count == 0
- count  output  CNT_WIDTH  number of valid entries

Behaviour:
- Reset (rst_n low at a clk edge):
  - Pointers, count, flushPending and flushDone are cleared.
  - FSM goes to IDLE and memReq goes to 0.
  - Entry storage is not reset; validity is derived from the pointers only.
  - Reset overrides everything, including an in-flight request: that store is lost, and memory must tolerate memReq dropping.
- Storage:
  - Circular FIFO with head and tail pointers of log2(DEPTH) bits that wrap modulo DEPTH.
  - A separate count runs 0..DEPTH.
- Enqueue:
  - enqReady = (count < DEPTH) && !flushPending. It does not consider a same-cycle pop; there is no fall-through when full.
  - The entry is written on an edge where enqValid && enqReady.
  - enqValid while enqReady=0 is ignored: no write, no state change. The stall logic must hold the store.
- FSM states are IDLE and DRAIN. memReq = (state == DRAIN).
  - IDLE: if count > 0, go to DRAIN next cycle. A store enqueued into an empty buffer at cycle N raises memReq at N+2.
  - DRAIN: memAddr, memData and memFunc3 come from the head entry and stay stable until memAck.
  - On memAck, the head is popped and head advances.
  - After the pop, stay in DRAIN if (count - 1 + same-cycle enqueue) > 0, otherwise go to IDLE. Back-to-back stores issue with no bubble.
  - memAck while memReq=0 is ignored.
- Simultaneous enqueue and pop: count is unchanged and both pointers advance.
- Load conflict (combinational):
  - ldConflict = ldCheckValid && some valid entry has addr[DATA_WIDTH-1:2] == ldCheckAddr[DATA_WIDTH-1:2].
  - Comparison is at word granularity, regardless of size.
  - The head entry counts until the edge on which memAck pops it.
  - Only entries valid at the start of the cycle are checked; a same-cycle enqueue is not.
- Flush:
  - A flush pulse sets flushPending, which blocks enqueue.
  - When flushPending && count == 0 && state == IDLE, flushDone pulses high for one cycle and flushPending clears on that edge.
  - A flush arriving while already empty and IDLE gives flushDone on the next cycle.
  - A flush while flushPending is already set has no extra effect.
- empty and count reflect registered state. They are not affected by same-cycle enqueue or pop.

Test Plan:
- Reset with count=3 mid-DRAIN -> next cycle count=0, empty=1, memReq=0, enqReady=1, flushDone=0.
- Single sw 0x0000_1004/0xDEADBEEF at cycle 0, memAck tied high -> memReq high at cycles 2 only with memAddr=0x1004, memData=0xDEADBEEF, memFunc3=010; empty=1 at cycle 3.
- Enqueue 4 stores with memAck=0 -> enqReady=0 when count=4; a 5th enqValid is dropped; raise memAck for 4 cycles -> writes retire in FIFO order with no gap between them; head/tail wrap is correct when a subsequent 4 stores are enqueued and drained.
- With memAck held low, stall cycles are inserted between acks and the payload stays constant throughout; simultaneous enqueue plus ack at count=2 keeps count=2.
- Queue sb to 0x2003, then load check 0x2000 -> ldConflict=1; load check 0x2004 -> 0; after the sb is acked, load check 0x2000 -> 0.
- 3 queued stores + flush pulse -> enqReady=0 until drained; flushDone pulses exactly once, the cycle after the FSM is IDLE with count 0; then enqReady=1. Flush when already empty -> flushDone on the next cycle.
